abp_receiver_frame_rx: RTL and testbench
========================================

Name: abp_receiver_frame_rx

Overview:
- Receiver-side Alternating Bit Protocol (ABP) data-frame receiver. It sits upstream of the receiver acknowledgment transmitter.
- Consumes data frames from the link over AXI-Stream and buffers each complete frame (store-and-forward).
- Checks frame length and sequence bit. Forwards the payload of new good frames downstream.
- Drives ack_bit, the sequence bit the acknowledgment transmitter latches and echoes back to the sender.
- Duplicate and malformed frames are dropped and counted.

Parameters:
- FRAME_BYTES, 64: total frame length in bytes, header included; legal range 2..256.
- CNT_WIDTH, 16: width of each saturating statistics counter.

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- s_axis_tvalid  input  1  link frame byte valid
- s_axis_tready  output  1  ready for a link frame byte
- s_axis_tlast  input  1  last byte of the link frame
- s_axis_tdata  input  8  link frame byte
- m_axis_tvalid  output  1  payload byte valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last payload byte
- m_axis_tdata  output  8  payload byte
- ack_bit  output  1  sequence bit of the last accepted frame; connects to the acknowledgment transmitter's alternating_bit input
- busy  output  1  high while a frame is being received or forwarded
- frames_ok  output  CNT_WIDTH  count of accepted new frames
- frames_dup  output  CNT_WIDTH  count of dropped duplicate frames
- frames_err  output  CNT_WIDTH  count of dropped malformed frames

Behaviour:
- Reset is aresetn, asynchronous, active-low; the clock is aclk.
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - ack_bit=1, meaning no frame accepted yet.
  - Internal expected sequence bit exp=0.
  - All counters 0. State=HDR.
  - s_axis_tready rises on the first clock edge after reset release.
- Frame format:
  - Byte 0 is the header; only bit 0 is used and it is the sequence bit seq. Header bits 7:1 are ignored.
  - Bytes 1..FRAME_BYTES-1 are payload.
  - s_axis_tlast is required on byte FRAME_BYTES-1 and only there.
- Transfer rule: a byte is transferred when valid and ready are both high on a rising edge. Both interfaces follow AXI-Stream rules: once m_axis_tvalid is asserted, data and last are held until accepted.
- States:
  - HDR (s_axis_tready=1):
    - On header transfer, capture seq, set idx=1 and busy=1, go to PAY.
    - A header transferred with tlast=1 is a malformed frame: frames_err++, return to HDR.
  - PAY (s_axis_tready=1): write each byte to buffer[idx-1] and increment idx.
    - tlast on byte index FRAME_BYTES-1 with seq==exp (good new frame):
      - ack_bit<=seq, exp<=~exp, frames_ok++, go to FWD.
    - tlast on byte index FRAME_BYTES-1 with seq!=exp (duplicate):
      - Drop the frame; ack_bit is unchanged. frames_dup++, busy=0, go to HDR.
    - tlast before index FRAME_BYTES-1 (short frame): frames_err++, busy=0, go to HDR.
    - Byte index FRAME_BYTES-1 without tlast (long frame): go to DISC.
  - DISC (s_axis_tready=1): sink bytes until a tlast transfer, then frames_err++, busy=0, go to HDR.
  - FWD (s_axis_tready=0):
    - Present buffer[0..FRAME_BYTES-2] in order. m_axis_tlast=1 on the final byte.
    - m_axis_tvalid is first high on the cycle after the committing edge (latency 1).
    - One byte per cycle while m_axis_tready=1; stalls hold the current byte stable.
    - After the tlast byte transfers: m_axis_tvalid=0, busy=0, go to HDR.
- ack_bit timing: changes only on the edge that commits a good frame. It is never changed by duplicates, errors or downstream stalls.
- Statistics counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Simultaneous events:
  - No upstream byte is accepted while in FWD; backpressure reaches the link.
  - Exactly one counter increments per completed or aborted frame.
- Reset mid-operation: the partial frame or the partial forward is abandoned with no further output. Downstream must tolerate a missing tlast after reset.
- Buffer: single-port RAM, depth FRAME_BYTES-1, 8 bits wide, write in PAY, read in FWD. An output register gives the latency above.

Test Plan:
- FRAME_BYTES=8. Send a frame with header 0x00 and payload 1..7, tlast on byte 7, m_axis_tready=1:
  - ack_bit goes 1->0 on the tlast edge; frames_ok=1.
  - Payload 1..7 appears on m_axis starting the next cycle, tlast on 7.
- Resend the identical seq=0 frame:
  - No m_axis output; ack_bit stays 0; frames_dup=1; s_axis_tready stays 1.
- Send a seq=1 frame with payload 0xA0..0xA6 while m_axis_tready toggles 1,0,1,0:
  - All 7 bytes are delivered in order and held stable during stalls.
  - s_axis_tready=0 throughout forwarding; ack_bit=1; frames_ok=2.
- Send a short frame (tlast on byte 4) and then a long frame (12 bytes, tlast on byte 11):
  - frames_err=2; no m_axis output; ack_bit unchanged.
  - A following good frame with seq=0 is accepted normally.
- Assert aresetn low while byte 3 of a frame is being received, and separately while forwarding byte 2:
  - All outputs return to reset values immediately: ack_bit=1, counters 0, m_axis_tvalid=0.
  - A fresh seq=0 frame afterwards is accepted.
- Force frames_dup to 0xFFFF, then send a duplicate: frames_dup stays 0xFFFF.

Source files
------------

// File: rtl/abp_receiver_frame_rx.sv
// Alternating Bit Protocol data-frame receiver: stores each link frame, checks its
// length and sequence bit, forwards payloads of new good frames and drives ack_bit.
module abp_receiver_frame_rx #(
    parameter int FRAME_BYTES = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [7:0]           s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [7:0]           m_axis_tdata,
    output logic                 ack_bit,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_ok,
    output logic [CNT_WIDTH-1:0] frames_dup,
    output logic [CNT_WIDTH-1:0] frames_err
);

    localparam int IDX_W  = $clog2(FRAME_BYTES);
    localparam int ADDR_W = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES - 1) : 1;
    localparam int DEPTH  = FRAME_BYTES - 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 2);

    // Valid/ready: a byte moves on a rising edge where valid and ready are both high;
    // a presented m_axis byte (data, last) is held unchanged until it moves.
    typedef enum logic [1:0] {HDR, PAY, DISC, FWD} state_t;

    state_t               state, state_nxt;
    logic                 ready_en;
    logic                 exp_bit;
    logic                 seq;
    logic                 ack_q;
    logic [IDX_W-1:0]     idx;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W-1:0]    wr_addr;
    logic [7:0]           mem [0:DEPTH-1];
    logic [7:0]           first_byte;
    logic                 m_valid_q;
    logic                 m_last_q;
    logic [7:0]           m_data_q;
    logic [CNT_WIDTH-1:0] ok_cnt, dup_cnt, err_cnt;
    logic                 s_xfer, m_xfer, at_last_idx;
    logic                 inc_ok, inc_dup, inc_err;

    assign s_axis_tready = ready_en && (state != FWD);
    assign s_xfer        = s_axis_tvalid && s_axis_tready;
    assign m_xfer        = m_valid_q && m_axis_tready;
    assign at_last_idx   = (idx == LAST_IDX);
    assign wr_addr       = ADDR_W'(idx - IDX_W'(1));
    // With a one-byte payload the first byte is still being written on the commit edge.
    assign first_byte    = (LAST_ADDR == '0) ? s_axis_tdata : mem[0];

    always_comb begin
        state_nxt = state;
        inc_ok    = 1'b0;
        inc_dup   = 1'b0;
        inc_err   = 1'b0;
        case (state)
            HDR: begin
                if (s_xfer) begin
                    if (s_axis_tlast) inc_err = 1'b1;
                    else              state_nxt = PAY;
                end
            end
            PAY: begin
                if (s_xfer) begin
                    if (s_axis_tlast) begin
                        state_nxt = HDR;
                        if (!at_last_idx) begin
                            inc_err = 1'b1;
                        end else if (seq == exp_bit) begin
                            inc_ok    = 1'b1;
                            state_nxt = FWD;
                        end else begin
                            inc_dup = 1'b1;
                        end
                    end else if (at_last_idx) begin
                        state_nxt = DISC;
                    end
                end
            end
            DISC: begin
                if (s_xfer && s_axis_tlast) begin
                    inc_err   = 1'b1;
                    state_nxt = HDR;
                end
            end
            FWD: begin
                if (m_xfer && m_last_q) state_nxt = HDR;
            end
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= HDR;
            ready_en  <= 1'b0;
            exp_bit   <= 1'b0;
            seq       <= 1'b0;
            ack_q     <= 1'b1;
            idx       <= '0;
            rd_ptr    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            ok_cnt    <= '0;
            dup_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (state == HDR && s_xfer) begin
                seq <= s_axis_tdata[0];
                idx <= IDX_W'(1);
            end
            if (state == PAY && s_xfer) idx <= idx + IDX_W'(1);
            if (inc_ok) begin
                ack_q     <= seq;
                exp_bit   <= ~exp_bit;
                m_valid_q <= 1'b1;
                m_data_q  <= first_byte;
                m_last_q  <= (LAST_ADDR == '0);
                rd_ptr    <= ADDR_W'(1);
            end
            if (state == FWD && m_xfer) begin
                if (m_last_q) begin
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end else begin
                    m_data_q <= mem[rd_ptr];
                    m_last_q <= (rd_ptr == LAST_ADDR);
                    rd_ptr   <= rd_ptr + ADDR_W'(1);
                end
            end
            // Counters saturate rather than wrap.
            if (inc_ok  && ok_cnt  != '1) ok_cnt  <= ok_cnt  + CNT_WIDTH'(1);
            if (inc_dup && dup_cnt != '1) dup_cnt <= dup_cnt + CNT_WIDTH'(1);
            if (inc_err && err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (state == PAY && s_xfer) mem[wr_addr] <= s_axis_tdata;
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_data_q;
    assign ack_bit       = ack_q;
    assign busy          = (state != HDR);
    assign frames_ok     = ok_cnt;
    assign frames_dup    = dup_cnt;
    assign frames_err    = err_cnt;

endmodule

// File: tb/tb_abp_receiver_frame_rx.sv
// Randomised scoreboard bench for abp_receiver_frame_rx: a frame-level reference
// model predicts payload beats, ack_bit and the saturating counters.
module tb_abp_receiver_frame_rx;

    localparam int FB   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [7:0]    s_axis_tdata = 8'h00;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [7:0]    m_axis_tdata;
    logic          ack_bit;
    logic          busy;
    logic [CW-1:0] frames_ok, frames_dup, frames_err;

    always #5 aclk = ~aclk;

    abp_receiver_frame_rx #(.FRAME_BYTES(FB), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .ack_bit(ack_bit), .busy(busy),
        .frames_ok(frames_ok), .frames_dup(frames_dup), .frames_err(frames_err)
    );

    int total = 0;
    int bad   = 0;
    int pop_cnt = 0;
    int ready_mode = 0;
    logic [8:0] exp_q[$];

    // Reference model state
    int m_exp = 0, m_ack = 1, m_ok = 0, m_dup = 0, m_err = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    // Monitor: values at the falling edge are the ones the next rising edge acts on.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = 9'h0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall <= 1'b0;
        end else if (m_axis_tvalid) begin
            chk("s_tready_low_during_fwd", int'(s_axis_tready), 0);
            if (prev_stall) chk("stall_hold", int'({m_axis_tlast, m_axis_tdata}), int'(prev_beat));
            if (m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got last=%0d data=0x%0h expected no output",
                             m_axis_tlast, m_axis_tdata);
                end else begin
                    chk("m_beat", int'({m_axis_tlast, m_axis_tdata}), int'(exp_q.pop_front()));
                end
                pop_cnt++;
            end
            prev_stall <= !m_axis_tready;
            prev_beat  <= {m_axis_tlast, m_axis_tdata};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit done = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("s_byte_accept_timeout", 0, 1);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge aclk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        chk("idle_reached", int'(done), 1);
        chk("busy_idle", int'(busy), 0);
        chk("ack_idle", int'(ack_bit), m_ack);
        chk("frames_ok", int'(frames_ok), m_ok);
        chk("frames_dup", int'(frames_dup), m_dup);
        chk("frames_err", int'(frames_err), m_err);
    endtask

    // pat < 0 gives a random payload, otherwise payload byte i is pat+i.
    task automatic send_frame(input int n, input logic [7:0] hdr, input int pat, input bit do_wait);
        logic [7:0] b[$];
        bit good;
        b.push_back(hdr);
        for (int i = 1; i < n; i++)
            b.push_back((pat < 0) ? 8'($urandom_range(0, 255)) : 8'(pat + i - 1));
        good = (n == FB) && (int'(hdr[0]) == m_exp);
        if (n == FB) begin
            if (good) begin
                for (int i = 1; i < n; i++) exp_q.push_back({i == n - 1, b[i]});
                m_ack = int'(hdr[0]);
                m_exp = 1 - m_exp;
                m_ok  = sat_inc(m_ok);
            end else begin
                m_dup = sat_inc(m_dup);
            end
        end else begin
            m_err = sat_inc(m_err);
        end
        for (int i = 0; i < n; i++) begin
            if (ready_mode == 2 && $urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            send_byte(b[i], i == n - 1);
        end
        chk("ack_after_last", int'(ack_bit), m_ack);
        chk("m_valid_latency", int'(m_axis_tvalid), int'(good));
        chk("s_tready_after_last", int'(s_axis_tready), good ? 0 : 1);
        if (do_wait) wait_idle();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        chk("rst_s_tready", int'(s_axis_tready), 0);
        chk("rst_m_valid", int'(m_axis_tvalid), 0);
        chk("rst_m_last", int'(m_axis_tlast), 0);
        chk("rst_m_data", int'(m_axis_tdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack_bit), 1);
        chk("rst_cnt_ok", int'(frames_ok), 0);
        chk("rst_cnt_dup", int'(frames_dup), 0);
        chk("rst_cnt_err", int'(frames_err), 0);
        exp_q.delete();
        m_exp = 0; m_ack = 1; m_ok = 0; m_dup = 0; m_err = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("s_tready_before_edge", int'(s_axis_tready), 0);
        @(posedge aclk);
        #1;
        chk("s_tready_after_edge", int'(s_axis_tready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit hit;
        @(posedge aclk);
        #1;
        do_reset();

        // Basic good frame, then its duplicate
        send_frame(FB, 8'h00, 1, 1);
        send_frame(FB, 8'h00, 1, 1);

        // seq=1 frame with alternating downstream stalls
        ready_mode = 1;
        send_frame(FB, 8'h01, 8'hA0, 1);
        ready_mode = 0;

        // Short, long and header-only frames, then a good frame with junk header bits
        send_frame(5, 8'h00, 8'h30, 1);
        send_frame(12, 8'h00, 8'h40, 1);
        send_frame(1, 8'h00, 0, 1);
        send_frame(FB, 8'hFE, 8'h10, 1);

        // Reset while byte 3 is offered
        send_byte(8'h00, 1'b0);
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h53;
        do_reset();
        send_frame(FB, 8'h00, 8'h60, 1);

        // Reset while forwarding
        p0 = pop_cnt;
        send_frame(FB, 8'h01, 8'h70, 0);
        hit = 0;
        for (int n = 0; n < 50; n++) begin
            if (pop_cnt >= p0 + 2) begin
                hit = 1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        chk("fwd_two_beats", int'(hit), 1);
        do_reset();
        repeat (3) @(posedge aclk);
        #1;
        send_frame(FB, 8'h00, 8'h80, 1);

        // Duplicate counter saturation
        for (int k = 0; k < CMAX + 2; k++) send_frame(FB, 8'h00, -1, 1);
        chk("dup_saturated", int'(frames_dup), CMAX);

        // Randomised mix
        do_reset();
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int n;
            n = ($urandom_range(0, 3) < 3) ? FB : int'($urandom_range(1, 12));
            send_frame(n, 8'($urandom_range(0, 255)), -1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
